// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters,
// holding operands for ALU_LAT cycles, then returning result/zero as a one-cycle pulse.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW = 4,
  parameter int ALU_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             grant_id
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic rr_q, rr_d, grant_q, grant_d, zero_q, zero_d, win, acc;
  logic [3:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OPW-1:0] op_q, op_d;
  always_comb begin
    win = (req0_valid && req1_valid) ? rr_q : req1_valid;
    acc = (state_q == IDLE) && !reset && (req0_valid || req1_valid);
    req0_ready = acc && !win;
    req1_ready = acc && win;
    resp0_valid = (state_q == RESP) && !grant_q;
    resp1_valid = (state_q == RESP) && grant_q;
    state_d = state_q;
    rr_d = rr_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    res_d = res_q;
    zero_d = zero_q;
    unique case (state_q)
      IDLE: if (acc) begin
        state_d = EXEC;
        a_d = win ? req1_a : req0_a;
        b_d = win ? req1_b : req0_b;
        op_d = win ? req1_op : req0_op;
        grant_d = win;
        rr_d = !win;
        cnt_d = 4'(ALU_LAT - 1);
      end
      EXEC: begin
        cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          res_d = alu_result;
          zero_d = alu_zero;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      grant_q <= 1'b0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      res_q <= res_d;
      zero_q <= zero_d;
    end
  end
  assign busy = state_q != IDLE;
  assign grant_id = grant_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  assign resp_result = res_q;
  assign resp_zero = zero_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: transaction-timeline model of the arbiter checked every cycle,
// plus directed literal checks and ALU_LAT=1/15 side instances.
module tb_alu_share_arbiter;
  localparam int LAT = 2;
  logic clk = 0, reset = 1;
  logic req0_valid = 0, req1_valid = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0] req0_op = 0, req1_op = 0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp_zero, busy, grant_id, alu_zero;
  logic [31:0] resp_result, alu_a, alu_b, alu_result;
  logic [3:0] alu_op;
  int total = 0, bad = 0;
  longint cyc = 0;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, b, input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);
  assign alu_zero = alu_result == 32'd0;

  alu_share_arbiter #(.ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id)
  );

  logic [1:0] xv = 0;
  wire [1:0] xr0, xr1, xs0, xs1, xz, xbusy, xg, xaz;
  wire [31:0] xres [2];
  wire [31:0] xaa [2];
  wire [31:0] xab [2];
  wire [31:0] xar [2];
  wire [3:0] xao [2];
  for (genvar g = 0; g < 2; g++) begin : gx
    assign xar[g] = alu_fn(xaa[g], xab[g], xao[g]);
    assign xaz[g] = xar[g] == 32'd0;
    alu_share_arbiter #(.ALU_LAT(g ? 15 : 1)) ux (
      .clk(clk), .reset(reset),
      .req0_valid(xv[g]), .req0_ready(xr0[g]), .req0_a(32'hFFFF_FFFF), .req0_b(32'hFFFF_FFFF), .req0_op(4'd1),
      .req1_valid(1'b0), .req1_ready(xr1[g]), .req1_a(32'd0), .req1_b(32'd0), .req1_op(4'd0),
      .resp0_valid(xs0[g]), .resp1_valid(xs1[g]), .resp_result(xres[g]), .resp_zero(xz[g]),
      .alu_a(xaa[g]), .alu_b(xab[g]), .alu_op(xao[g]), .alu_result(xar[g]), .alu_zero(xaz[g]),
      .busy(xbusy[g]), .grant_id(xg[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask

  // Model: an accepted op occupies the ALU for cycles acc+1..acc+LAT+1, responding at acc+LAT+1.
  bit armed = 0, m_rr = 0, m_g = 0, out_z = 0;
  logic [31:0] m_a = 0, m_b = 0, out_res = 0;
  logic [3:0] m_op = 0;
  longint free_at = 0, resp_at = -1;
  always @(negedge clk) begin
    bit idle, e_r0, e_r1;
    e_r0 = 0;
    e_r1 = 0;
    if (armed) begin
      idle = cyc >= free_at;
      if (cyc == resp_at) begin
        out_res = alu_fn(m_a, m_b, m_op);
        out_z = out_res == 32'd0;
      end
      e_r0 = idle && !reset && req0_valid && (!req1_valid || !m_rr);
      e_r1 = idle && !reset && req1_valid && (!req0_valid || m_rr);
      chk("ready0", req0_ready, e_r0);
      chk("ready1", req1_ready, e_r1);
      chk("resp0", resp0_valid, cyc == resp_at && !m_g);
      chk("resp1", resp1_valid, cyc == resp_at && m_g);
      chk("busy", busy, !idle);
      chk("grant_id", grant_id, m_g);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
      chk("resp_result", resp_result, out_res);
      chk("resp_zero", resp_zero, out_z);
    end
    if (reset) begin
      armed = 1; m_rr = 0; m_g = 0; m_a = 0; m_b = 0; m_op = 0;
      out_res = 0; out_z = 0; free_at = cyc + 1; resp_at = -1;
    end else if (e_r0 || e_r1) begin
      m_g = e_r1;
      m_rr = !e_r1;
      m_a = e_r1 ? req1_a : req0_a;
      m_b = e_r1 ? req1_b : req0_b;
      m_op = e_r1 ? req1_op : req0_op;
      resp_at = cyc + LAT + 1;
      free_at = cyc + LAT + 2;
    end
  end

  task automatic issue(input bit p, input logic [31:0] a, b, input logic [3:0] op, output longint t);
    @(posedge clk); #1;
    if (p) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    else begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    t = -1;
    for (int k = 0; k < 40 && t < 0; k++) begin
      @(negedge clk);
      if (p ? req1_ready : req0_ready) t = cyc;
    end
    if (t < 0) begin total++; bad++; $display("FAIL issue%0d timeout", p); end
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    longint t, t0;
    longint tr [2];
    int n;
    bit ids [6];
    longint ts [6];
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_result", resp_result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_grant", grant_id, 0);
    // side instances: ALU_LAT=1 and 15 with all-ones SUB
    @(posedge clk); #1 xv = 2'b11;
    @(negedge clk);
    chk("x_ready", xr0, 2'b11);
    t0 = cyc;
    tr[0] = -1;
    tr[1] = -1;
    @(posedge clk); #1 xv = 2'b00;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (xs0[i] && tr[i] < 0) begin
          tr[i] = cyc;
          chk("x_zero", xz[i], 1);
          chk("x_result", xres[i], 0);
          chk("x_resp1", xs1[i], 0);
        end
    end
    chk("x_lat1", 32'(tr[0] - t0), 2);
    chk("x_lat15", 32'(tr[1] - t0), 16);
    // req0 5-5
    issue(0, 5, 5, 4'd1, t);
    repeat (3) @(negedge clk);
    chk("d1_resp0", resp0_valid, 1);
    chk("d1_resp1", resp1_valid, 0);
    chk("d1_result", resp_result, 0);
    chk("d1_zero", resp_zero, 1);
    // req1 9-4
    issue(1, 9, 4, 4'd1, t);
    @(negedge clk);
    chk("d2_grant", grant_id, 1);
    repeat (2) @(negedge clk);
    chk("d2_resp1", resp1_valid, 1);
    chk("d2_result", resp_result, 5);
    chk("d2_zero", resp_zero, 0);
    // contention from reset
    do_reset();
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 0;
    req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = 0;
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin ids[n] = req1_ready; ts[n] = cyc; n++; end
    end
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
    chk("rr_count", n, 6);
    for (int i = 0; i < n; i++) chk("rr_order", ids[i], i % 2);
    for (int i = 1; i < n; i++) chk("rr_spacing", 32'(ts[i] - ts[i-1]), 4);
    // operand change during EXEC
    issue(0, 7, 3, 4'd0, t);
    req0_a = 100;
    req1_a = 200;
    repeat (2) @(negedge clk);
    chk("hold_alu_a", alu_a, 7);
    @(negedge clk);
    chk("hold_resp0", resp0_valid, 1);
    chk("hold_result", resp_result, 10);
    // reset one cycle into EXEC
    issue(1, 8, 8, 4'd1, t);
    reset = 1;
    repeat (2) @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_grant", grant_id, 0);
    chk("mr_alu_a", alu_a, 0);
    chk("mr_alu_b", alu_b, 0);
    chk("mr_alu_op", alu_op, 0);
    chk("mr_result", resp_result, 0);
    chk("mr_zero", resp_zero, 0);
    chk("mr_resp", {resp0_valid, resp1_valid}, 0);
    chk("mr_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1 reset = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mr_no_resp", resp1_valid, 0);
    end
    @(posedge clk); #1;
    req0_valid = 1;
    req1_valid = 1;
    @(negedge clk);
    chk("mr_first_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      reset = $urandom_range(0, 299) == 0;
      req0_valid = $urandom_range(0, 9) < 6;
      req1_valid = $urandom_range(0, 9) < 6;
      req0_a = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7);
      req0_b = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7);
      req1_a = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7);
      req1_b = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7);
      req0_op = 4'($urandom_range(0, 5));
      req1_op = 4'($urandom_range(0, 5));
    end
    @(posedge clk); #1;
    reset = 0;
    req0_valid = 0;
    req1_valid = 0;
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
